// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank: frames write live registers directly or stage
// them for a later frame-boundary load.
module spi_reg_bank #(
  parameter int unsigned NREGS  = 6,
  parameter int unsigned REG_W  = 15,
  parameter int unsigned ADDR_W = 3,
  parameter logic [NREGS*REG_W-1:0] INIT = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_sclk,
  input  logic                   i_ss_n,
  input  logic                   i_mosi,
  input  logic                   load_if_ready,
  output logic [NREGS*REG_W-1:0] regs_out,
  output logic                   pending,
  output logic                   frame_err
);

  localparam int unsigned F     = 1 + ADDR_W + REG_W;
  localparam int unsigned CNT_W = $clog2(F);
  localparam int unsigned BANK_W = NREGS * REG_W;

  logic [2:0]        sclk_sync;
  logic [1:0]        ss_sync;
  logic [1:0]        mosi_sync;
  logic              sclk_rise;
  logic              ss_active;
  logic              mosi_s;

  logic [CNT_W-1:0]  bit_cnt;
  logic [F-1:0]      shift_q;
  logic              done_q;

  logic [BANK_W-1:0] stage_q;
  logic [NREGS-1:0]  dirty_q;
  logic [BANK_W-1:0] live_d;
  logic [BANK_W-1:0] stage_d;
  logic [NREGS-1:0]  dirty_d;

  logic              f_mode;
  logic [ADDR_W-1:0] f_addr;
  logic [REG_W-1:0]  f_data;
  logic              addr_ok;
  logic              commit_c;
  logic              last_bit;

  assign sclk_rise = (sclk_sync[2:1] == 2'b01);
  assign ss_active = ~ss_sync[1];
  assign mosi_s    = mosi_sync[1];

  assign f_mode   = shift_q[F-1];
  assign f_addr   = shift_q[REG_W +: ADDR_W];
  assign f_data   = shift_q[REG_W-1:0];
  assign addr_ok  = (32'(f_addr) < NREGS);
  assign commit_c = done_q && addr_ok;
  assign last_bit = (bit_cnt == CNT_W'(F - 1));

  // Synchronisers, bit counter and frame capture.
  // shift_q is stable on the commit edge: sclk_rise cannot fire on two consecutive clk edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_sclk};
      ss_sync   <= {ss_sync[0], i_ss_n};
      mosi_sync <= {mosi_sync[0], i_mosi};
      done_q    <= 1'b0;
      frame_err <= done_q && !addr_ok;
      if (!ss_active) begin
        bit_cnt <= '0;
        if (bit_cnt != '0) frame_err <= 1'b1;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[F-2:0], mosi_s};
        if (last_bit) begin
          bit_cnt <= '0;
          done_q  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Next register state: load applies to the old stage, then the commit overrides.
  always_comb begin
    live_d  = regs_out;
    stage_d = stage_q;
    dirty_d = dirty_q;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (load_if_ready && dirty_q[k]) begin
        live_d[k*REG_W +: REG_W] = stage_q[k*REG_W +: REG_W];
        dirty_d[k]               = 1'b0;
      end
      if (commit_c && (f_addr == ADDR_W'(k))) begin
        if (f_mode) begin
          live_d[k*REG_W +: REG_W] = f_data;
        end else begin
          stage_d[k*REG_W +: REG_W] = f_data;
          dirty_d[k]                = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_out <= INIT;
      stage_q  <= '0;
      dirty_q  <= '0;
      pending  <= 1'b0;
    end else begin
      regs_out <= live_d;
      stage_q  <= stage_d;
      dirty_q  <= dirty_d;
      pending  <= |dirty_d;
    end
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter NREGS, default 6, SHALL set the number of live/staged registers (1..64).
REQ-002 Parameter REG_W, default 15, SHALL set the width of every register in bits (1..32).
REQ-003 Parameter ADDR_W, default 3, SHALL set the address field width, and SHALL satisfy 2**ADDR_W >= NREGS.
REQ-004 Parameter INIT, default all-zero (NREGS*REG_W bits), SHALL hold the flattened reset values, with register k at bits [k*REG_W +: REG_W].
REQ-005 Port clk, input, 1 bit: system clock, rising edge.
REQ-006 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 Ports i_sclk, i_ss_n, i_mosi, input, 1 bit each: asynchronous SPI mode-0 slave inputs.
REQ-008 Port load_if_ready, input, 1 bit: frame-boundary strobe that permits staged data to go live.
REQ-009 Port regs_out, output, NREGS*REG_W bits: flattened live registers, in the same layout as INIT.
REQ-010 Port pending, output, 1 bit: high while any staged register awaits load.
REQ-011 Port frame_err, output, 1 bit: one-cycle pulse on an aborted frame or an out-of-range address.

Function
REQ-012 i_sclk SHALL pass a 3-flop synchroniser; sclk_rise SHALL be stage[2:1]==2'b01.
REQ-013 i_ss_n and i_mosi SHALL pass 2-flop synchronisers; ss_active SHALL be the inverted stage-2 value of i_ss_n.
REQ-014 Frame length SHALL be F = 1+ADDR_W+REG_W bits, MSB first: mode bit, then address, then data.
REQ-015 Mode 1 SHALL select an immediate write; mode 0 SHALL select a staged write.
REQ-016 Each sclk_rise with ss_active SHALL shift the synchronised mosi into a shift register and increment the bit counter.
REQ-017 On the last bit (counter==F-1), the counter SHALL wrap to 0, so back-to-back frames under one continuous /SS are accepted.
REQ-018 The clk edge that samples the last bit is edge E; the frame SHALL commit on edge E+1 (registered done flag).
REQ-019 At commit, an address >= NREGS SHALL pulse frame_err and change no register.
REQ-020 An immediate commit SHALL write live[addr]; regs_out SHALL therefore reflect the new value after edge E+1.
REQ-021 A staged commit SHALL write stage[addr] and set dirty[addr].
REQ-022 pending SHALL equal the OR of all dirty bits.
REQ-023 On an edge with load_if_ready=1, every register with dirty set SHALL copy stage to live and clear its dirty bit; clean registers SHALL be unchanged.
REQ-024 A load with no dirty bits set SHALL be a no-op.
REQ-025 Staged commit and load on the same edge, same address: load SHALL use the old stage value; the new value SHALL remain staged with dirty=1.
REQ-026 Immediate commit and load on the same edge, same address: the immediate data SHALL win; that dirty bit SHALL be cleared.
REQ-027 If ss_active deasserts with counter != 0, the counter SHALL return to 0, frame_err SHALL pulse for one cycle, and nothing SHALL commit.
REQ-028 While ss_active is low, the counter SHALL be held at 0.

Reset
REQ-029 On reset: live registers SHALL load INIT; stage, dirty, counter, shift register, done flag and frame_err SHALL clear to 0.
REQ-030 On reset, the i_ss_n synchroniser SHALL preset to 1 (inactive), and the sclk synchroniser SHALL clear to 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame with no frame_err pulse.
REQ-032 Reset SHALL take priority over load_if_ready and over any commit.

Verification (NREGS=6, REG_W=15, ADDR_W=3, F=19, INIT reg0=0x0300)
REQ-033 Release reset -> reg0=0x0300, pending=0, frame_err=0.
REQ-034 Staged frame addr 2, data 0x1234 -> pending=1 and reg2 unchanged; then load_if_ready pulse -> reg2=0x1234 and pending=0 after that edge.
REQ-035 Immediate frame addr 1, data 0x7EEF -> reg1=0x7EEF at edge E+1; pending unaffected.
REQ-036 Raise /SS after 10 bits -> single frame_err pulse and no register change; a following full frame commits normally.
REQ-037 Two frames under one /SS (staged addr 3 =0x0005, immediate addr 6) -> addr 3 is staged, addr 6 pulses frame_err, live registers are unchanged.
REQ-038 Staged commit to addr 4 coincident with load_if_ready while addr 4 is dirty with 0x0001 (new data 0x0002) -> reg4=0x0001, pending stays 1; next load gives reg4=0x0002.
